// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared width and FSM encodings for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DMEM_RESP = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = DMEM_IDLE,
    ST_WAIT = DMEM_WAIT,
    ST_RESP = DMEM_RESP
  } dmem_state_e;

  // A simultaneous read and write is serviced as a store.
  function automatic logic is_load(input logic rd, input logic wr);
    return rd & ~wr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_read_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_read_buffer
// Description : Single-entry tag/data/valid load buffer with store update.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_read_buffer #(
  parameter int WORD_SIZE = dmem_responder_pkg::WORD_SIZE,
  parameter bit ENABLE    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] i_lookup_addr,
  output logic                 o_hit,
  output logic [WORD_SIZE-1:0] o_data,
  input  logic                 i_fill_en,
  input  logic [WORD_SIZE-1:0] i_fill_addr,
  input  logic [WORD_SIZE-1:0] i_fill_data,
  input  logic                 i_upd_en,
  input  logic [WORD_SIZE-1:0] i_upd_addr,
  input  logic [WORD_SIZE-1:0] i_upd_data
);

  logic                 r_valid;
  logic [WORD_SIZE-1:0] r_tag;
  logic [WORD_SIZE-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill_en) begin
      r_valid <= ENABLE;
      r_tag   <= i_fill_addr;
      r_data  <= i_fill_data;
    end else if (i_upd_en && (r_tag == i_upd_addr)) begin
      // Write-through keeps the cached copy coherent with memory.
      r_data  <= i_upd_data;
    end
  end

  assign o_hit  = ENABLE && r_valid && (r_tag == i_lookup_addr);
  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : MEM-stage load/store responder with req/ack memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int WORD_SIZE       = dmem_responder_pkg::WORD_SIZE,
  parameter bit USE_READ_BUFFER = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_mem_read,
  input  logic                 d_mem_write,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 d_next_ready,
  output logic [WORD_SIZE-1:0] d_written_address,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack
);

  import dmem_responder_pkg::*;

  dmem_state_e          r_state;
  logic                 r_op_we;
  logic [WORD_SIZE-1:0] r_op_addr;
  logic [WORD_SIZE-1:0] r_op_wdata;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [WORD_SIZE-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0] r_mem_wdata;
  logic                 r_resp_ready;
  logic [WORD_SIZE-1:0] r_rdata;
  logic [WORD_SIZE-1:0] r_written_addr;

  logic                 w_buf_hit;
  logic [WORD_SIZE-1:0] w_buf_data;
  logic                 w_hit;
  logic                 w_start;
  logic                 w_fill_en;
  logic                 w_upd_en;

  assign w_hit     = (r_state == ST_IDLE) && is_load(d_mem_read, d_mem_write) && w_buf_hit;
  assign w_start   = (r_state == ST_IDLE) && (d_mem_read || d_mem_write) && !w_hit;
  assign w_fill_en = (r_state == ST_RESP) && !r_op_we;
  assign w_upd_en  = (r_state == ST_RESP) && r_op_we;

  dmem_read_buffer #(
    .WORD_SIZE (WORD_SIZE),
    .ENABLE    (USE_READ_BUFFER)
  ) u_read_buffer (
    .clk           (clk),
    .rst           (reset),
    .i_lookup_addr (d_address),
    .o_hit         (w_buf_hit),
    .o_data        (w_buf_data),
    .i_fill_en     (w_fill_en),
    .i_fill_addr   (r_op_addr),
    .i_fill_data   (r_rdata),
    .i_upd_en      (w_upd_en),
    .i_upd_addr    (r_op_addr),
    .i_upd_data    (r_op_wdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_op_we        <= 1'b0;
      r_op_addr      <= '0;
      r_op_wdata     <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_resp_ready   <= 1'b0;
      r_rdata        <= '0;
      r_written_addr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_op_we     <= d_mem_write;
            r_op_addr   <= d_address;
            r_op_wdata  <= d_wdata;
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_mem_write;
            r_mem_addr  <= d_address;
            r_mem_wdata <= d_wdata;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The MEM-stage request is not sampled here; the transaction runs to completion.
          if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_resp_ready <= 1'b1;
            r_rdata      <= r_op_we ? '0 : mem_rdata;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_resp_ready <= 1'b0;
          r_rdata      <= '0;
          if (r_op_we) begin
            r_written_addr <= r_op_addr;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign d_ready           = r_resp_ready | w_hit;
  assign d_rdata           = w_hit ? w_buf_data : r_rdata;
  assign d_next_ready      = (r_state == ST_WAIT) && mem_ack;
  assign d_written_address = r_written_addr;
  assign mem_req           = r_mem_req;
  assign mem_we            = r_mem_we;
  assign mem_addr          = r_mem_addr;
  assign mem_wdata         = r_mem_wdata;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory-side responder for the pipelined TSC core. It is the other end of the MEM-stage load/store handshake: it produces d_ready, d_next_ready and d_written_address, which the hazard logic consumes.
- Accepts one load or store from the MEM stage and runs a req/ack transaction on the external memory port.
- A single-entry read buffer returns repeated loads in zero wait cycles. Stores write through and update the buffer.

Parameters:
- WORD_SIZE, 16: data and address width.
- USE_READ_BUFFER, 1: 0 disables the buffer, so every load misses.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- d_mem_read  in  1  MEM-stage load request. Held stable until d_ready.
- d_mem_write  in  1  MEM-stage store request. Held stable until d_ready.
- d_address  in  WORD_SIZE  load/store address.
- d_wdata  in  WORD_SIZE  store data.
- d_rdata  out  WORD_SIZE  load data. Valid only while d_ready=1 for a load.
- d_ready  out  1  transaction completes this cycle.
- d_next_ready  out  1  d_ready will be 1 next cycle.
- d_written_address  out  WORD_SIZE  address of the most recently completed store.
- mem_req  out  1  external request. Held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  WORD_SIZE  external address.
- mem_wdata  out  WORD_SIZE  external write data.
- mem_rdata  in  WORD_SIZE  external read data. Valid with mem_ack.
- mem_ack  in  1  external completion, 1-cycle pulse.

Behaviour:
- Reset (async, any state):
  - state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - d_ready=0, d_next_ready=0, d_rdata=0, d_written_address=0.
  - Buffer invalid.
- FSM states: IDLE, WAIT, RESP.
- IDLE, load hit (buf_valid && buf_addr==d_address && USE_READ_BUFFER):
  - d_ready=1 combinationally in the same cycle; d_rdata=buf_data.
  - Stay IDLE; no external access.
- IDLE, load miss or any store:
  - At the edge, latch the request into op_we, op_addr, op_wdata.
  - Drive mem_req=1, mem_we=op_we, mem_addr=op_addr, mem_wdata=op_wdata from registers.
  - Go to WAIT. d_ready stays 0 that cycle.
- IDLE, d_mem_read and d_mem_write both 1: treated as a store.
- WAIT:
  - mem_req held, with address, data and we constant, until mem_ack.
  - In the mem_ack cycle: d_next_ready=1; capture mem_rdata into resp_data (loads); clear mem_req at the edge; go to RESP.
  - mem_ack is ignored outside WAIT.
- RESP, exactly one cycle:
  - d_ready=1; d_rdata=resp_data for a load, 0 for a store.
  - Load: buffer <= {op_addr, resp_data}, valid.
  - Store: d_written_address <= op_addr. If the buffer address equals op_addr, buf_data <= op_wdata.
  - Go to IDLE.
- Minimum miss latency: request at cycle 0, mem_ack at cycle 1, d_ready at cycle 2. Each extra ack delay adds 1 cycle.
- Back-to-back requests:
  - The request visible in IDLE on the cycle after RESP is a new transaction, even with identical address and operation.
  - A load immediately after a store to the same address hits with the stored data.
- Request deasserted while in WAIT (protocol violation):
  - The external transaction completes normally.
  - RESP still pulses d_ready; the buffer and d_written_address still update.
- d_next_ready is never 1 in IDLE or RESP, and never 1 on a buffer hit.
- Width: addresses and data are WORD_SIZE bits. There is no address arithmetic or wrap behaviour.

Decomposition:
- Shared constants file (next to constants.v):
  - WORD_SIZE.
  - FSM state encodings DMEM_IDLE, DMEM_WAIT, DMEM_RESP (2-bit).
- Natural sub-module: dmem_read_buffer, the single-entry tag/data/valid register with lookup, fill and store-update ports.
- The FSM and the external port stay in dmem_responder.

Test Plan:
- Reset during WAIT (mem_req=1) -> mem_req=0 immediately; state IDLE; a following load to the same address misses.
- Load 0x0010, mem_ack 3 cycles after mem_req with rdata 0xBEEF -> d_next_ready in the ack cycle; d_ready and d_rdata=0xBEEF the next cycle; mem_req cleared.
- Repeat load 0x0010 right after -> d_ready=1 in the same cycle, d_rdata=0xBEEF, mem_req stays 0.
- Store 0x0010 <- 0x1234, ack after 1 cycle -> mem_we=1, mem_wdata=0x1234; d_written_address=0x0010 after RESP.
- Then load 0x0010 -> zero-wait hit with d_rdata=0x1234.
- Load 0x0020 with USE_READ_BUFFER=0, issued twice -> both issue mem_req; neither returns d_ready in the request cycle.
- Hold mem_ack low for 20 cycles -> d_ready=0 and mem_req=1 throughout; address and data stable; d_next_ready=0 until ack.
